// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, downstream
// control (stall/redirect/halt), branch-predictor training and F/D outputs.
interface fetch_if;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        bp_update;
  logic [31:0] bp_pc;
  logic        bp_taken;
  logic        halt;
  logic        fd_valid;
  logic [31:0] fd_instr;
  logic [5:0]  fd_opcode;
  logic [31:0] fd_pc;
  logic        fd_taken;

  // Fetch stage side: consumes memory data and control, produces requests and F/D fields.
  modport master (
    input  ihit, imemload, stall, redirect, redirect_pc,
           bp_update, bp_pc, bp_taken, halt,
    output imemREN, imemaddr, fd_valid, fd_instr, fd_opcode, fd_pc, fd_taken
  );

  // Environment side: memory, hazard unit and EX-stage resolution.
  modport slave (
    output ihit, imemload, stall, redirect, redirect_pc,
           bp_update, bp_pc, bp_taken, halt,
    input  imemREN, imemaddr, fd_valid, fd_instr, fd_opcode, fd_pc, fd_taken
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, predicts BEQ/BNE with a 2-bit
// branch history table, resolves J/JAL targets locally and loads the F/D fields.
module fetch_stage #(
  parameter logic [31:0] PC_INIT     = 32'h0000_0000,
  parameter int          BHT_ENTRIES = 16
) (
  input logic     CLK,
  input logic     nRST,
  fetch_if.master fif
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

  // Saturating 2-bit counter step: 00 and 11 are sticky at the ends.
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken) begin
      if (cnt != 2'b11) res = cnt + 2'd1;
    end else begin
      if (cnt != 2'b00) res = cnt - 2'd1;
    end
    return res;
  endfunction

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fd_valid_q, fd_valid_d;
  logic [31:0] fd_instr_q, fd_instr_d;
  logic [5:0]  fd_opcode_q, fd_opcode_d;
  logic [31:0] fd_pc_q, fd_pc_d;
  logic        fd_taken_q, fd_taken_d;
  logic [BHT_ENTRIES-1:0][1:0] bht_q, bht_d;

  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              predict_taken;
  logic [5:0]        load_op;
  logic [31:0]       pc4;
  logic [31:0]       jmp_target;
  logic signed [31:0] br_off;
  logic [31:0]       br_target;

  assign fif.imemREN   = (state_q == RUN);
  assign fif.imemaddr  = pc_q;
  assign fif.fd_valid  = fd_valid_q;
  assign fif.fd_instr  = fd_instr_q;
  assign fif.fd_opcode = fd_opcode_q;
  assign fif.fd_pc     = fd_pc_q;
  assign fif.fd_taken  = fd_taken_q;

  // Prediction and candidate targets, all combinational off the current PC and fetched word.
  always_comb begin
    rd_idx        = pc_q[IDX_W+1:2];
    predict_taken = bht_q[rd_idx][1];
    load_op       = fif.imemload[31:26];
    pc4           = pc_q + 32'd4;
    jmp_target    = {pc4[31:28], fif.imemload[25:0], 2'b00};
    br_off        = {{14{fif.imemload[15]}}, fif.imemload[15:0], 2'b00};
    br_target     = pc4 + unsigned'(br_off);
  end

  // Next-PC and F/D selection: halt, then redirect, then stall, then hit/miss.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fd_valid_d  = fd_valid_q;
    fd_instr_d  = fd_instr_q;
    fd_opcode_d = fd_opcode_q;
    fd_pc_d     = fd_pc_q;
    fd_taken_d  = fd_taken_q;
    if (fif.halt || (state_q == HALTED)) begin
      state_d    = HALTED;
      fd_valid_d = 1'b0;
    end else if (fif.redirect) begin
      pc_d        = fif.redirect_pc;
      fd_valid_d  = 1'b0;
      fd_instr_d  = '0;
      fd_opcode_d = '0;
      fd_pc_d     = '0;
      fd_taken_d  = 1'b0;
    end else if (!fif.stall) begin
      if (fif.ihit) begin
        fd_instr_d  = fif.imemload;
        fd_opcode_d = load_op;
        fd_pc_d     = pc_q;
        fd_valid_d  = 1'b1;
        if ((load_op == OP_J) || (load_op == OP_JAL)) begin
          pc_d       = jmp_target;
          fd_taken_d = 1'b1;
        end else if (((load_op == OP_BEQ) || (load_op == OP_BNE)) && predict_taken) begin
          pc_d       = br_target;
          fd_taken_d = 1'b1;
        end else begin
          pc_d       = pc4;
          fd_taken_d = 1'b0;
        end
      end else begin
        // Miss: PC waits for the memory, the latch shows a bubble.
        fd_valid_d = 1'b0;
      end
    end
  end

  // BHT training runs regardless of stall/halt; prediction above reads the pre-update value.
  always_comb begin
    bht_d  = bht_q;
    wr_idx = fif.bp_pc[IDX_W+1:2];
    if (fif.bp_update) begin
      bht_d[wr_idx] = sat_update(bht_q[wr_idx], fif.bp_taken);
    end
  end

  // State registers; synchronous active-low reset overrides every other input.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= RUN;
      pc_q        <= PC_INIT;
      fd_valid_q  <= 1'b0;
      fd_instr_q  <= '0;
      fd_opcode_q <= '0;
      fd_pc_q     <= '0;
      fd_taken_q  <= 1'b0;
      bht_q       <= {BHT_ENTRIES{2'b01}};
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fd_valid_q  <= fd_valid_d;
      fd_instr_q  <= fd_instr_d;
      fd_opcode_q <= fd_opcode_d;
      fd_pc_q     <= fd_pc_d;
      fd_taken_q  <= fd_taken_d;
      bht_q       <= bht_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by randomized traffic,
// all compared every cycle against an instruction-level reference model.
module tb_fetch_stage;
  localparam logic [31:0] PC_INIT     = 32'h0000_0000;
  localparam int          BHT_ENTRIES = 16;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  fetch_if fif ();

  fetch_stage #(.PC_INIT(PC_INIT), .BHT_ENTRIES(BHT_ENTRIES)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .fif (fif)
  );

  // Reference model state
  logic [31:0] m_pc, m_instr, m_fdpc;
  logic        m_valid, m_taken, m_halted;
  int          m_bht[BHT_ENTRIES];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the fetch stage, described as instruction semantics.
  task automatic model_edge();
    logic [31:0] pc4;
    logic [5:0]  op;
    logic        pred;
    int          idx;
    int          off;
    if (!nRST) begin
      m_pc = PC_INIT; m_halted = 1'b0; m_valid = 1'b0;
      m_instr = '0; m_fdpc = '0; m_taken = 1'b0;
      foreach (m_bht[i]) m_bht[i] = 1;
      return;
    end
    idx  = int'((m_pc >> 2) % BHT_ENTRIES);
    pred = (m_bht[idx] >= 2);
    if (fif.halt || m_halted) begin
      m_halted = 1'b1;
      m_valid  = 1'b0;
    end else if (fif.redirect) begin
      m_pc = fif.redirect_pc; m_valid = 1'b0;
      m_instr = '0; m_fdpc = '0; m_taken = 1'b0;
    end else if (!fif.stall) begin
      if (fif.ihit) begin
        op      = fif.imemload[31:26];
        pc4     = m_pc + 32'd4;
        m_instr = fif.imemload;
        m_fdpc  = m_pc;
        m_valid = 1'b1;
        if (op == 6'h02 || op == 6'h03) begin
          m_pc    = (pc4 & 32'hF000_0000) | ({6'b0, fif.imemload[25:0]} << 2);
          m_taken = 1'b1;
        end else if ((op == 6'h04 || op == 6'h05) && pred) begin
          off     = int'($signed(fif.imemload[15:0])) * 4;
          m_pc    = pc4 + 32'(off);
          m_taken = 1'b1;
        end else begin
          m_pc    = pc4;
          m_taken = 1'b0;
        end
      end else begin
        m_valid = 1'b0;
      end
    end
    if (fif.bp_update) begin
      idx = int'((fif.bp_pc >> 2) % BHT_ENTRIES);
      if (fif.bp_taken) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
      else              m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
    end
  endtask

  // Advance one clock with the currently driven inputs and compare every output.
  task automatic cycle();
    model_edge();
    @(posedge CLK);
    #1;
    chk("imemaddr",  fif.imemaddr,  m_pc);
    chk("imemREN",   fif.imemREN,   !m_halted);
    chk("fd_valid",  fif.fd_valid,  m_valid);
    chk("fd_instr",  fif.fd_instr,  m_instr);
    chk("fd_opcode", fif.fd_opcode, m_instr[31:26]);
    chk("fd_pc",     fif.fd_pc,     m_fdpc);
    chk("fd_taken",  fif.fd_taken,  m_taken);
  endtask

  task automatic idle();
    fif.ihit = 1'b0; fif.imemload = '0; fif.stall = 1'b0;
    fif.redirect = 1'b0; fif.redirect_pc = '0;
    fif.bp_update = 1'b0; fif.bp_pc = '0; fif.bp_taken = 1'b0;
    fif.halt = 1'b0;
  endtask

  task automatic go_to(input logic [31:0] target);
    idle();
    fif.redirect = 1'b1; fif.redirect_pc = target;
    cycle();
    fif.redirect = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc, input logic taken, input int times);
    idle();
    fif.bp_update = 1'b1; fif.bp_pc = pc; fif.bp_taken = taken;
    for (int i = 0; i < times; i++) cycle();
    fif.bp_update = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    case ($urandom_range(5, 0))
      0: op = 6'h00;
      1: op = 6'h02;
      2: op = 6'h03;
      3: op = 6'h04;
      4: op = 6'h05;
      default: op = 6'($urandom);
    endcase
    return {op, 26'($urandom)};
  endfunction

  localparam logic [31:0] BEQ_BACK = 32'h1000_FFFC;  // BEQ $0,$0,-4 words
  localparam logic [31:0] J_100    = 32'h0800_0040;  // J imm26=0x40

  int halted_cycles;

  initial begin
    idle();
    nRST = 1'b0;
    cycle();
    chk("rst_addr", fif.imemaddr, 32'h0);
    chk("rst_ren",  fif.imemREN,  1'b1);
    nRST = 1'b1;

    // Steady NOP stream: one instruction per cycle, fd_pc one behind.
    fif.ihit = 1'b1; fif.imemload = 32'h0;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      chk("nop_addr",  fif.imemaddr, 32'(i * 4));
      chk("nop_fdpc",  fif.fd_pc,    32'((i - 1) * 4));
      chk("nop_valid", fif.fd_valid, 1'b1);
    end

    // BEQ at 0x10 with weakly-not-taken counter falls through.
    fif.imemload = BEQ_BACK;
    cycle();
    chk("beq_nt_addr",  fif.imemaddr, 32'h14);
    chk("beq_nt_taken", fif.fd_taken, 1'b0);

    // Two taken resolutions at 0x10 (first one alongside a redirect back).
    idle();
    fif.redirect = 1'b1; fif.redirect_pc = 32'h10;
    fif.bp_update = 1'b1; fif.bp_pc = 32'h10; fif.bp_taken = 1'b1;
    cycle();
    fif.redirect = 1'b0;
    cycle();
    idle();
    fif.ihit = 1'b1; fif.imemload = BEQ_BACK;
    cycle();
    chk("beq_t_addr",  fif.imemaddr, 32'h04);
    chk("beq_t_taken", fif.fd_taken, 1'b1);

    // J at 0x20 resolved locally.
    go_to(32'h20);
    fif.ihit = 1'b1; fif.imemload = J_100;
    cycle();
    chk("j_addr",  fif.imemaddr, 32'h100);
    chk("j_taken", fif.fd_taken, 1'b1);
    chk("j_fdpc",  fif.fd_pc,    32'h20);

    // Stall with ihit: everything frozen.
    fif.imemload = 32'h0; fif.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_addr",  fif.imemaddr, 32'h100);
      chk("stall_fdpc",  fif.fd_pc,    32'h20);
      chk("stall_valid", fif.fd_valid, 1'b1);
    end
    fif.redirect = 1'b1; fif.redirect_pc = 32'h200;
    cycle();
    chk("stall_redir_valid", fif.fd_valid, 1'b0);
    chk("stall_redir_addr",  fif.imemaddr, 32'h200);

    // Memory misses produce bubbles and hold the PC.
    idle();
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("miss_valid", fif.fd_valid, 1'b0);
      chk("miss_addr",  fif.imemaddr, 32'h200);
    end

    // Halt beats a same-cycle redirect and is sticky until reset.
    fif.redirect = 1'b1; fif.redirect_pc = 32'h300; fif.halt = 1'b1;
    cycle();
    chk("halt_ren",  fif.imemREN,  1'b0);
    chk("halt_addr", fif.imemaddr, 32'h200);
    idle();
    fif.ihit = 1'b1;
    cycle();
    chk("halt_stay_addr", fif.imemaddr, 32'h200);
    chk("halt_stay_ren",  fif.imemREN,  1'b0);
    nRST = 1'b0;
    cycle();
    nRST = 1'b1;
    chk("rerst_addr", fif.imemaddr, PC_INIT);

    // PC wraps from the top of the address space.
    go_to(32'hFFFF_FFFC);
    fif.ihit = 1'b1; fif.imemload = 32'h0;
    cycle();
    chk("wrap_addr", fif.imemaddr, 32'h0);
    chk("wrap_fdpc", fif.fd_pc,    32'hFFFF_FFFC);

    // Counter saturation at index of 0x40 (BEQ target 0x34, fall-through 0x44).
    train(32'h40, 1'b1, 4);
    go_to(32'h40);
    fif.ihit = 1'b1; fif.imemload = BEQ_BACK;
    cycle();
    chk("sat_hi_addr", fif.imemaddr, 32'h34);
    train(32'h40, 1'b0, 4);
    go_to(32'h40);
    fif.ihit = 1'b1; fif.imemload = BEQ_BACK;
    cycle();
    chk("sat_lo_addr", fif.imemaddr, 32'h44);
    train(32'h40, 1'b1, 2);
    go_to(32'h40);
    // Predict with the old counter (10) while the same entry is trained down.
    fif.ihit = 1'b1; fif.imemload = BEQ_BACK;
    fif.bp_update = 1'b1; fif.bp_pc = 32'h40; fif.bp_taken = 1'b0;
    cycle();
    chk("same_cyc_addr",  fif.imemaddr, 32'h34);
    chk("same_cyc_taken", fif.fd_taken, 1'b1);
    go_to(32'h40);
    fif.ihit = 1'b1; fif.imemload = BEQ_BACK;
    cycle();
    chk("after_upd_addr", fif.imemaddr, 32'h44);

    // Randomized traffic against the model.
    halted_cycles = 0;
    for (int n = 0; n < 3000; n++) begin
      idle();
      fif.ihit      = ($urandom_range(99, 0) < 70);
      fif.imemload  = rand_instr();
      fif.stall     = ($urandom_range(99, 0) < 15);
      fif.redirect  = ($urandom_range(99, 0) < 6);
      fif.redirect_pc = ($urandom_range(9, 0) == 0) ? 32'hFFFF_FFF8
                                                    : (32'($urandom_range(255, 0)) << 2);
      fif.bp_update = ($urandom_range(99, 0) < 30);
      fif.bp_pc     = 32'($urandom_range(255, 0)) << 2;
      fif.bp_taken  = $urandom_range(1, 0) == 1;
      fif.halt      = ($urandom_range(199, 0) == 0);
      if (m_halted) halted_cycles++;
      else          halted_cycles = 0;
      nRST = !(($urandom_range(299, 0) == 0) || (halted_cycles > 3));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
